// File: rtl/kronos_tohost_monitor.sv
// kronos_tohost_monitor: watches the arbitrated data bus of a test core.
// Tracks the run from the first fetch, decodes the tohost mailbox into
// PASS/FAIL, enforces a RUN-cycle budget (TIMEOUT), and folds writes into
// the signature window into a rolling checksum.
module kronos_tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [31:0] SIG_BEGIN      = 32'h0000_1800,
  parameter logic [31:0] SIG_END        = 32'h0000_2000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        enable,
  input  logic        mem_req,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic [3:0]  mem_mask,
  input  logic        instr_ack,
  output logic [2:0]  state,
  output logic        done,
  output logic        done_pulse,
  output logic [30:0] fail_code,
  output logic [31:0] cycle_count,
  output logic [31:0] fetch_count,
  output logic [15:0] sig_wr_count,
  output logic [31:0] sig_checksum,
  output logic        proto_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic        done_pulse_q, done_pulse_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [15:0] sig_wr_count_q, sig_wr_count_d;
  logic [31:0] sig_checksum_q, sig_checksum_d;
  logic        proto_err_q, proto_err_d;

  // Bus decode: only word granularity matters, byte offset is irrelevant.
  logic        wr_cycle;
  logic        tohost_word;
  logic        tohost_hit;
  logic        tohost_partial;
  logic [31:0] word_addr;
  logic        in_sig_window;
  logic        live;
  logic        sig_hit;
  logic        timeout_hit;
  logic [31:0] masked_data;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^mem_addr[1:0];
  assign wr_cycle        = enable & mem_req & mem_wr_en;
  assign tohost_word     = (mem_addr[31:2] == TOHOST_ADDR[31:2]);
  assign tohost_hit      = wr_cycle & tohost_word & (mem_mask == 4'hF);
  assign tohost_partial  = wr_cycle & tohost_word & (mem_mask != 4'hF);
  assign word_addr       = {mem_addr[31:2], 2'b00};
  assign in_sig_window   = (word_addr >= SIG_BEGIN) && (word_addr < SIG_END);
  assign live            = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign sig_hit         = wr_cycle & in_sig_window & live;
  assign timeout_hit     = (cycle_count_q == TIMEOUT_CYCLES - 32'd1);
  assign masked_data     = mem_wr_data & {{8{mem_mask[3]}}, {8{mem_mask[2]}},
                                          {8{mem_mask[1]}}, {8{mem_mask[0]}}};

  // Next-state and next-output computation for the run monitor.
  always_comb begin
    // NOTE: every _d starts as its _q so no branch can leave it unassigned (no latch).
    state_d        = state_q;
    done_d         = done_q;
    done_pulse_d   = done_pulse_q;
    fail_code_d    = fail_code_q;
    cycle_count_d  = cycle_count_q;
    fetch_count_d  = fetch_count_q;
    sig_wr_count_d = sig_wr_count_q;
    sig_checksum_d = sig_checksum_q;
    proto_err_d    = proto_err_q;

    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (instr_ack) begin
            state_d       = ST_RUN;
            fetch_count_d = fetch_count_q + 32'd1;
          end
        end
        ST_RUN: begin
          if (cycle_count_q != 32'hFFFF_FFFF) cycle_count_d = cycle_count_q + 32'd1;
          if (instr_ack && (fetch_count_q != 32'hFFFF_FFFF)) fetch_count_d = fetch_count_q + 32'd1;
          // Bit 0 clear is a syscall encoding and is ignored; a tohost hit beats timeout.
          if (tohost_hit && mem_wr_data[0]) begin
            fail_code_d = mem_wr_data[31:1];
            state_d     = (mem_wr_data[31:1] == 31'd0) ? ST_PASS : ST_FAIL;
          end else if (timeout_hit) begin
            state_d = ST_TIMEOUT;
          end
        end
        default: ;
      endcase

      if (sig_hit) begin
        sig_checksum_d = {sig_checksum_q[30:0], sig_checksum_q[31]} ^ masked_data;
        if (sig_wr_count_q != 16'hFFFF) sig_wr_count_d = sig_wr_count_q + 16'd1;
      end

      if (tohost_partial) proto_err_d = 1'b1;

      done_d       = state_d inside {ST_PASS, ST_FAIL, ST_TIMEOUT};
      done_pulse_d = done_d & ~done_q;
    end
  end

  // State and result registers, cleared asynchronously by rstz.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q        <= ST_IDLE;
      done_q         <= 1'b0;
      done_pulse_q   <= 1'b0;
      fail_code_q    <= '0;
      cycle_count_q  <= '0;
      fetch_count_q  <= '0;
      sig_wr_count_q <= '0;
      sig_checksum_q <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      state_q        <= state_d;
      done_q         <= done_d;
      done_pulse_q   <= done_pulse_d;
      fail_code_q    <= fail_code_d;
      cycle_count_q  <= cycle_count_d;
      fetch_count_q  <= fetch_count_d;
      sig_wr_count_q <= sig_wr_count_d;
      sig_checksum_q <= sig_checksum_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign state        = state_q;
  assign done         = done_q;
  assign done_pulse   = done_pulse_q;
  assign fail_code    = fail_code_q;
  assign cycle_count  = cycle_count_q;
  assign fetch_count  = fetch_count_q;
  assign sig_wr_count = sig_wr_count_q;
  assign sig_checksum = sig_checksum_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_kronos_tohost_monitor.sv
// Testbench for kronos_tohost_monitor: two instances (default budget and a
// 5-cycle budget) share one stimulus stream; both are compared every cycle
// against a behavioural model, with directed scenarios followed by random runs.
module tb_kronos_tohost_monitor;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam logic [31:0] SIG_B  = 32'h0000_1800;
  localparam logic [31:0] SIG_E  = 32'h0000_2000;
  localparam logic [31:0] TMO_A  = 32'd1_000_000;
  localparam logic [31:0] TMO_B  = 32'd5;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic        enable = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic [3:0]  mem_mask = '0;
  logic        instr_ack = 1'b0;

  logic [2:0]  a_state, b_state;
  logic        a_done, b_done, a_pulse, b_pulse, a_perr, b_perr;
  logic [30:0] a_fc, b_fc;
  logic [31:0] a_cyc, b_cyc, a_fetch, b_fetch, a_chk, b_chk;
  logic [15:0] a_sigc, b_sigc;

  int n_tests = 0;
  int n_fail  = 0;

  kronos_tohost_monitor #(
    .TOHOST_ADDR(TOHOST), .SIG_BEGIN(SIG_B), .SIG_END(SIG_E), .TIMEOUT_CYCLES(TMO_A)
  ) dut_a (
    .clk(clk), .rstz(rstz), .enable(enable), .mem_req(mem_req), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_mask(mem_mask),
    .instr_ack(instr_ack), .state(a_state), .done(a_done), .done_pulse(a_pulse),
    .fail_code(a_fc), .cycle_count(a_cyc), .fetch_count(a_fetch),
    .sig_wr_count(a_sigc), .sig_checksum(a_chk), .proto_err(a_perr)
  );

  kronos_tohost_monitor #(
    .TOHOST_ADDR(TOHOST), .SIG_BEGIN(SIG_B), .SIG_END(SIG_E), .TIMEOUT_CYCLES(TMO_B)
  ) dut_b (
    .clk(clk), .rstz(rstz), .enable(enable), .mem_req(mem_req), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_mask(mem_mask),
    .instr_ack(instr_ack), .state(b_state), .done(b_done), .done_pulse(b_pulse),
    .fail_code(b_fc), .cycle_count(b_cyc), .fetch_count(b_fetch),
    .sig_wr_count(b_sigc), .sig_checksum(b_chk), .proto_err(b_perr)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0=idle, 1=running, 2=pass, 3=fail, 4=timeout.
  typedef struct {
    int unsigned st;
    logic        done;
    logic        pulse;
    logic [30:0] fc;
    logic [31:0] cyc;
    logic [31:0] fetch;
    logic [15:0] sigc;
    logic [31:0] chk;
    logic        perr;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = 0; r.done = 0; r.pulse = 0; r.fc = '0; r.cyc = '0;
    r.fetch = '0; r.sigc = '0; r.chk = '0; r.perr = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, logic [31:0] tmo);
    mdl_t        n;
    logic [31:0] wa, md;
    logic [63:0] spent;
    bit          wr, at_th;
    n = m;
    if (!enable) return m;
    wr    = mem_req && mem_wr_en;
    wa    = mem_addr & 32'hFFFF_FFFC;
    at_th = wr && (wa == (TOHOST & 32'hFFFF_FFFC));
    if (at_th && mem_mask != 4'hF) n.perr = 1;
    if ((m.st < 2) && wr && wa >= SIG_B && wa < SIG_E) begin
      md = '0;
      for (int b = 0; b < 4; b++) if (mem_mask[b]) md[8*b +: 8] = mem_wr_data[8*b +: 8];
      n.chk = ((m.chk << 1) | (m.chk >> 31)) ^ md;
      if (m.sigc != 16'hFFFF) n.sigc = m.sigc + 16'd1;
    end
    if (m.st == 0) begin
      if (instr_ack) begin
        n.st    = 1;
        n.fetch = m.fetch + 32'd1;
      end
    end else if (m.st == 1) begin
      spent = {32'd0, m.cyc} + 64'd1;
      n.cyc = (spent > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : spent[31:0];
      if (instr_ack && m.fetch != 32'hFFFF_FFFF) n.fetch = m.fetch + 32'd1;
      if (at_th && mem_mask == 4'hF && mem_wr_data[0]) begin
        n.fc = mem_wr_data[31:1];
        n.st = (mem_wr_data == 32'd1) ? 2 : 3;
      end else if (spent == {32'd0, tmo}) begin
        n.st = 4;
      end
    end
    n.done  = (n.st >= 2);
    n.pulse = n.done && !m.done;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a.state", {29'd0, a_state}, ma.st);
    check("a.done", {31'd0, a_done}, {31'd0, ma.done});
    check("a.done_pulse", {31'd0, a_pulse}, {31'd0, ma.pulse});
    check("a.fail_code", {1'b0, a_fc}, {1'b0, ma.fc});
    check("a.cycle_count", a_cyc, ma.cyc);
    check("a.fetch_count", a_fetch, ma.fetch);
    check("a.sig_wr_count", {16'd0, a_sigc}, {16'd0, ma.sigc});
    check("a.sig_checksum", a_chk, ma.chk);
    check("a.proto_err", {31'd0, a_perr}, {31'd0, ma.perr});
    check("b.state", {29'd0, b_state}, mb.st);
    check("b.done", {31'd0, b_done}, {31'd0, mb.done});
    check("b.done_pulse", {31'd0, b_pulse}, {31'd0, mb.pulse});
    check("b.fail_code", {1'b0, b_fc}, {1'b0, mb.fc});
    check("b.cycle_count", b_cyc, mb.cyc);
    check("b.fetch_count", b_fetch, mb.fetch);
    check("b.sig_wr_count", {16'd0, b_sigc}, {16'd0, mb.sigc});
    check("b.sig_checksum", b_chk, mb.chk);
    check("b.proto_err", {31'd0, b_perr}, {31'd0, mb.perr});
  endtask

  // One clock: models advance with the inputs the DUTs sampled, then compare.
  task automatic tick();
    @(posedge clk);
    ma = step(ma, TMO_A);
    mb = step(mb, TMO_B);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rstz = 1'b0;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    check_all();
    #1;
    rstz = 1'b1;
  endtask

  task automatic bus_idle();
    mem_req = 0; mem_wr_en = 0; mem_addr = '0; mem_wr_data = '0; mem_mask = '0; instr_ack = 0;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    mem_req = 1; mem_wr_en = 1; mem_addr = addr; mem_wr_data = data; mem_mask = mask;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ma = mdl_reset();
    mb = mdl_reset();
    enable = 1;
    #3;
    do_reset();
    check("reset state", {29'd0, a_state}, 32'd0);
    check("reset checksum", a_chk, 32'd0);

    // Ack, 10 idle cycles, tohost PASS; short-budget instance times out on the way.
    @(negedge clk);
    #0;
    instr_ack = 1;
    tick();
    instr_ack = 0;
    check("ack fetch_count", a_fetch, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 3) check("b still run", {29'd0, b_state}, 32'd1);
      if (i == 4) begin
        check("b timeout state", {29'd0, b_state}, 32'd4);
        check("b timeout cycles", b_cyc, 32'd5);
        check("b timeout pulse", {31'd0, b_pulse}, 32'd1);
      end
    end
    bus_wr(TOHOST, 32'h1, 4'hF);
    tick();
    bus_idle();
    check("pass state", {29'd0, a_state}, 32'd2);
    check("pass pulse", {31'd0, a_pulse}, 32'd1);
    check("pass fail_code", {1'b0, a_fc}, 32'd0);
    check("pass cycles", a_cyc, 32'd11);
    tick();
    check("pulse drops", {31'd0, a_pulse}, 32'd0);
    check("done holds", {31'd0, a_done}, 32'd1);

    // FAIL code capture, later writes ignored.
    do_reset();
    instr_ack = 1;
    tick();
    instr_ack = 0;
    bus_wr(TOHOST, 32'h7, 4'hF);
    tick();
    check("fail state", {29'd0, a_state}, 32'd3);
    check("fail code", {1'b0, a_fc}, 32'd3);
    bus_wr(TOHOST, 32'h1, 4'hF);
    tick();
    bus_idle();
    check("fail sticky state", {29'd0, a_state}, 32'd3);
    check("fail sticky code", {1'b0, a_fc}, 32'd3);

    // Signature writes accepted while idle.
    do_reset();
    bus_wr(SIG_B, 32'hA5A5_A5A5, 4'hF);
    tick();
    bus_wr(SIG_B, 32'h0000_00FF, 4'h1);
    tick();
    bus_idle();
    check("sig count", {16'd0, a_sigc}, 32'd2);
    check("sig checksum", a_chk, 32'h4B4B_4BB4);

    // Partial-mask tohost write flags protocol error; syscall write ignored.
    instr_ack = 1;
    tick();
    instr_ack = 0;
    bus_wr(TOHOST, 32'h1, 4'h3);
    tick();
    check("proto_err set", {31'd0, a_perr}, 32'd1);
    check("proto run", {29'd0, a_state}, 32'd1);
    bus_wr(TOHOST, 32'h2, 4'hF);
    tick();
    bus_idle();
    check("syscall run", {29'd0, a_state}, 32'd1);
    check("syscall code", {1'b0, a_fc}, 32'd0);

    // Tohost hit on the last budget cycle beats timeout; then reset mid-result.
    do_reset();
    instr_ack = 1;
    tick();
    instr_ack = 0;
    for (int i = 0; i < 4; i++) tick();
    check("b last budget cycle", b_cyc, 32'd4);
    bus_wr(TOHOST, 32'h1, 4'hF);
    tick();
    bus_idle();
    check("b pass over timeout", {29'd0, b_state}, 32'd2);
    check("b pass cycles", b_cyc, 32'd5);
    do_reset();
    check("post reset b state", {29'd0, b_state}, 32'd0);
    check("post reset b done", {31'd0, b_done}, 32'd0);
    check("post reset b cycles", b_cyc, 32'd0);
    tick();
    check("idle waits", {29'd0, a_state}, 32'd0);

    // Random runs against the model.
    for (int run = 0; run < 8; run++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        int unsigned sel;
        enable    = ($urandom_range(0, 9) != 0);
        instr_ack = ($urandom_range(0, 3) == 0);
        mem_req   = $urandom_range(0, 1);
        mem_wr_en = ($urandom_range(0, 3) != 0);
        mem_mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        sel = $urandom_range(0, 9);
        if (sel < 2) begin
          mem_addr    = TOHOST | 32'($urandom_range(0, 3));
          mem_wr_data = $urandom;
          mem_wr_data[0] = ($urandom_range(0, 7) == 0);
          if ($urandom_range(0, 1) == 0) mem_wr_data[31:1] = '0;
        end else if (sel < 6) begin
          mem_addr    = SIG_B - 32'd8 + 32'($urandom_range(0, 32'h810));
          mem_wr_data = $urandom;
        end else begin
          mem_addr    = $urandom;
          mem_wr_data = $urandom;
        end
        tick();
      end
      bus_idle();
      enable = 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
